// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_to_binary_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int         BCD_NIBBLE_W  = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] DD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] DD_ADJ_VAL    = 4'd3;

    // One shift per BCD bit, so the counter spans 0 .. 4*digits-1.
    function automatic int cnt_w(input int digits);
        return $clog2(BCD_NIBBLE_W * digits);
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Request/response bundle between keypad entry logic and the BCD-to-binary converter.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      bin_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (output start, bcd_in, input bin_out, busy, done, err);
    modport slave  (input start, bcd_in, output bin_out, busy, done, err);
endinterface

// File: rtl/bcd_to_binary_seq_nibble_adjust.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the nibble is >= 8.
module bcd_nibble_adjust
    import bcd_to_binary_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= DD_ADJ_THRESH) ? (din - DD_ADJ_VAL) : din;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional input digit validation when BCD2BIN_DIGIT_CHECK_EN is defined.
module bcd_to_binary_seq
    import bcd_to_binary_seq_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic               clk,
    input  logic               rst,
    bcd_to_binary_seq_if.slave bus
);
    localparam int                 BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int                 SR_W  = 2 * BCD_W;
    localparam int                 CNT_W = cnt_w(DIGITS);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BCD_W - 1);

    if ((64'd1 << BIN_W) <= (pow10(DIGITS) - 1)) begin : g_bad_width
        $error("bcd_to_binary_seq: BIN_W too small for DIGITS");
    end

    state_t                   state, state_n;
    logic [CNT_W-1:0]         cnt, cnt_n;
    logic [SR_W-1:0]          sr, sr_n, sh;
    logic [DIGITS-1:0][3:0]   sh_bcd, adj_bcd;
    logic [BCD_W-1:0]         bin_fld;
    logic [BIN_W-1:0]         bin_r, bin_n;
    logic                     done_r, done_n;

    // {bcd_field, bin_field} shifts right as one word; only the BCD half gets corrected.
    assign sh      = sr >> 1;
    assign sh_bcd  = sh[SR_W-1:BCD_W];
    assign bin_fld = sh[BCD_W-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .din  (sh_bcd[i]),
            .dout (adj_bcd[i])
        );
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic [DIGITS-1:0][3:0] in_dig;
    logic [DIGITS-1:0]      bad_dig;
    logic                   err_r, err_n;

    assign in_dig = bus.bcd_in;
    for (genvar i = 0; i < DIGITS; i++) begin : g_chk
        assign bad_dig[i] = in_dig[i] > BCD_MAX_DIGIT;
    end
    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        bin_n   = bin_r;
        done_n  = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_n   = err_r;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    if (|bad_dig) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                        bin_n  = '0;
                    end else
`endif
                    begin
                        sr_n    = {bus.bcd_in, {BCD_W{1'b0}}};
                        cnt_n   = '0;
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_n  = {adj_bcd, bin_fld};
                cnt_n = cnt + 1'b1;
                if (cnt == LAST) begin
                    // Final shift: the result is taken from this cycle's shifted word.
                    bin_n   = BIN_W'(bin_fld);
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    err_n   = 1'b0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sr     <= '0;
            bin_r  <= '0;
            done_r <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_r  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sr     <= sr_n;
            bin_r  <= bin_n;
            done_r <= done_n;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_r  <= err_n;
`endif
        end
    end

    assign bus.bin_out = bin_r;
    assign bus.done    = done_r;
    assign bus.busy    = (state == SHIFT);

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq (DIGITS=4, BIN_W=14).
module tb_bcd_to_binary_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bcd_to_binary_seq_if #(.DIGITS(4), .BIN_W(14)) bus ();

    bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) exp %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts edges from the accepting edge (1) through the done edge.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic convert(input logic [15:0] bcd, output int lat, output int bcnt);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        tick();
        bus.start  = 1'b0;
        bus.bcd_in = 16'h8888;
        wait_done(lat, bcnt);
    endtask

    initial begin
        int lat, bcnt, ndone;
        bus.start  = 1'b0;
        bus.bcd_in = 16'h0000;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_bin",  int'(bus.bin_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err",  int'(bus.err), 0);
        rst = 1'b0;
        tick();

        convert(16'h0000, lat, bcnt);
        chk("z_lat",  lat, 17);
        chk("z_busy", bcnt, 16);
        chk("z_bin",  int'(bus.bin_out), 0);
        chk("z_err",  int'(bus.err), 0);
        tick();
        chk("z_pulse", int'(bus.done), 0);

        convert(16'h9999, lat, bcnt);
        chk("n9999_lat", lat, 17);
        chk("n9999_bin", int'(bus.bin_out), 9999);
        tick();
        convert(16'h1234, lat, bcnt);
        chk("n1234_lat", lat, 17);
        chk("n1234_bin", int'(bus.bin_out), 1234);
        tick();

        convert(16'h12A4, lat, bcnt);
`ifdef BCD2BIN_DIGIT_CHECK_EN
        chk("bad_lat",  lat, 1);
        chk("bad_busy", bcnt, 0);
        chk("bad_err",  int'(bus.err), 1);
        chk("bad_bin",  int'(bus.bin_out), 0);
        tick();
        chk("bad_pulse", int'(bus.done), 0);
        chk("bad_hold",  int'(bus.err), 1);
`else
        chk("bad_lat",  lat, 17);
        chk("bad_busy", bcnt, 16);
        chk("bad_err",  int'(bus.err), 0);
        tick();
`endif

        // Second start mid-conversion must be dropped.
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0042;
        tick();
        bus.start  = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcnt++;
            if (lat == 5) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h0777;
            end else begin
                bus.start  = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk("ign_lat",  lat, 17);
        chk("ign_busy", bcnt, 16);
        chk("ign_bin",  int'(bus.bin_out), 42);
        chk("ign_err",  int'(bus.err), 0);

        // Back-to-back: start in the done cycle.
        convert(16'h0777, lat, bcnt);
        chk("b2b_lat", lat, 17);
        chk("b2b_bin", int'(bus.bin_out), 777);
        tick();

        // Reset mid-conversion abandons it.
        convert_abort: begin
            bus.start  = 1'b1;
            bus.bcd_in = 16'h5555;
            tick();
            bus.start  = 1'b0;
            for (int k = 0; k < 7; k++) tick();
            chk("ab_busy_pre", int'(bus.busy), 1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("ab_busy", int'(bus.busy), 0);
            chk("ab_done", int'(bus.done), 0);
            chk("ab_bin",  int'(bus.bin_out), 0);
            chk("ab_err",  int'(bus.err), 0);
            ndone = 0;
            for (int k = 0; k < 20; k++) begin
                if (bus.done || bus.busy) ndone++;
                tick();
            end
            chk("ab_quiet", ndone, 0);
        end

        convert(16'h0001, lat, bcnt);
        chk("one_lat", lat, 17);
        chk("one_bin", int'(bus.bin_out), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
